// File: rtl/prio_encoder_hs.sv
// prio_encoder_hs: registered N-to-log2(N) priority encoder with a sticky pending set and valid/ready output.
// Define PRIO_ENC_ROUND_ROBIN_EN to replace fixed highest-index priority with round-robin selection.
module prio_encoder_hs #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [W-1:0] out_code,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         any_pending,
   output logic         coalesced
);

   if (N < 2 || (N & (N - 1)) != 0 || W != $clog2(N)) begin : g_param_check
      $error("prio_encoder_hs: N must be a power of 2 >= 2 and W must equal log2(N)");
   end

   logic [N-1:0] pending;
   logic [N-1:0] grant;
   logic [W-1:0] sel_idx;
   logic         load;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
   logic [W-1:0] rr_ptr;
   logic [W-1:0] cand;
   logic         found;

   // Ascending search from rr_ptr+1; W-bit addition wraps at N because N is a power of 2.
   always_comb begin
      sel_idx = '0;
      cand    = '0;
      found   = 1'b0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = rr_ptr + W'(i);
         if (!found && pending[cand]) begin
            sel_idx = cand;
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= W'(N - 1);
      end else if (load) begin
         rr_ptr <= sel_idx;
      end
   end
`else
   always_comb begin
      sel_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (pending[i]) begin
            sel_idx = W'(i);
         end
      end
   end
`endif

   assign load        = (|pending) & (~out_valid | out_ready);
   assign grant       = load ? (N'(1) << sel_idx) : '0;
   assign any_pending = |pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         out_valid <= 1'b0;
         out_code  <= '0;
         coalesced <= 1'b0;
      end else begin
         pending   <= (pending & ~grant) | req;
         coalesced <= |(req & pending & ~grant);
         if (load) begin
            out_code  <= sel_idx;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Scoreboard bench for prio_encoder_hs: a reference model queues expected grant codes, a monitor checks them.
// Follows PRIO_ENC_ROUND_ROBIN_EN the same way as the design.
module tb_prio_encoder_hs;
   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic [W-1:0] out_code;
   logic         out_valid;
   logic         out_ready;
   logic         any_pending;
   logic         coalesced;

   int tests = 0;
   int fails = 0;
   int cnt5  = 0;

   prio_encoder_hs #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .out_code   (out_code),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .any_pending(any_pending),
      .coalesced  (coalesced)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: a set of pending request numbers, the code on offer, and the last granted index.
   bit [N-1:0] m_pending = '0;
   bit         m_valid   = 1'b0;
   int         m_code    = 0;
   bit         m_coal    = 1'b0;
   int         m_rr      = N - 1;
   int         exp_q[$];

   function automatic int pick(input bit [N-1:0] p, input int rr);
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++) begin
         if (p[(rr + k) % N]) return (rr + k) % N;
      end
`else
      for (int j = N - 1; j >= 0; j--) begin
         if (p[j]) return j;
      end
`endif
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int         g;
      bit         ld;
      bit [N-1:0] gm;
      if (!rst_n) begin
         m_pending <= '0;
         m_valid   <= 1'b0;
         m_code    <= 0;
         m_coal    <= 1'b0;
         m_rr      <= N - 1;
         exp_q.delete();
      end else begin
         ld = (m_pending != 0) && (!m_valid || out_ready);
         g  = ld ? pick(m_pending, m_rr) : -1;
         gm = ld ? (N'(1) << g) : '0;
         m_coal    <= |(req & m_pending & ~gm);
         m_pending <= (m_pending & ~gm) | req;
         if (ld) begin
            m_code  <= g;
            m_valid <= 1'b1;
            m_rr    <= g;
            exp_q.push_back(g);
         end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin : monitor
      int e;
      if (rst_n) begin
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("any_pending", 32'(any_pending), 32'(m_pending != 0));
         check("coalesced", 32'(coalesced), 32'(m_coal));
         if (m_valid) check("out_code_held", 32'(out_code), 32'(m_code));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_grant", 32'(out_code), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("grant_code", 32'(out_code), 32'(e));
               if (out_code == 3'd5) cnt5++;
            end
         end
      end
   end

   task automatic drive(input logic [N-1:0] r, input logic rdy);
      @(posedge clk);
      #1;
      req       = r;
      out_ready = rdy;
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = '0;
      out_ready = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_code", 32'(out_code), 0);
      check("rst_pending", 32'(any_pending), 0);
      check("rst_coal", 32'(coalesced), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // single request
      drive(8'h10, 1'b1);
      repeat (5) drive('0, 1'b1);

      // multi-hot drain
      drive(8'b1001_0110, 1'b1);
      repeat (7) drive('0, 1'b1);

      // backpressure
      drive(8'h03, 1'b0);
      repeat (5) drive('0, 1'b0);
      repeat (4) drive('0, 1'b1);

      // coalesce, then set-dominance on the grant of bit 5
      cnt5 = 0;
      drive(8'h80, 1'b0);
      drive(8'h20, 1'b0);
      drive(8'h20, 1'b0);
      drive(8'h20, 1'b1);
      repeat (4) drive('0, 1'b1);
      check("grants_of_5", 32'(cnt5), 2);

      // all requests held continuously
      repeat (20) drive(8'hFF, 1'b1);
      repeat (12) drive('0, 1'b1);

      // randomized traffic with random backpressure
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 3) == 0) ? N'($urandom) : '0, $urandom_range(0, 3) != 0);
      end

      // reset mid-stream with work pending and an output on offer
      drive(8'hA5, 1'b0);
      drive('0, 1'b0);
      drive('0, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 0);
      check("midrst_code", 32'(out_code), 0);
      check("midrst_pending", 32'(any_pending), 0);
      check("midrst_coal", 32'(coalesced), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive('0, 1'b1);
         #1 check("post_rst_idle", 32'(out_valid), 0);
      end

      // bounded drain
      for (int k = 0; k < 4; k++) drive(N'($urandom), 1'b1);
      for (int k = 0; k < 40 && (exp_q.size() != 0 || any_pending || out_valid); k++) begin
         drive('0, 1'b1);
      end
      @(negedge clk);
      check("drain_queue", 32'(exp_q.size()), 0);
      check("drain_pending", 32'(any_pending), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
